// File: rtl/mcycle_unit.sv
// Iterative shift-add multiplier / restoring divider with its own control FSM.
// One operation per Start handshake, fixed WIDTH+1 cycle latency to a Done pulse.
module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             mcycle_op_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] operand1_i,
    input  logic [WIDTH-1:0] operand2_i,
    output logic [WIDTH-1:0] result1_o,
    output logic [WIDTH-1:0] result2_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, COMPUTE, FINISH} state_e;

    typedef struct packed {
        logic op;    // 0 = multiply, 1 = divide
        logic sgn;
        logic s1;
        logic s2;
    } ctl_t;

    state_e             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    ctl_t               ctl_q, ctl_d;
    logic [WIDTH-1:0]   mag1_q, mag1_d;
    logic [WIDTH-1:0]   mag2_q, mag2_d;
    logic [WIDTH-1:0]   raw1_q, raw1_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   res1_q, res1_d;
    logic [WIDTH-1:0]   res2_q, res2_d;
    logic               dbz_q, dbz_d;
    logic               done_q, done_d;

    // Multiply: mag1 = multiplicand, mag2 = multiplier shifting right.
    // Divide: mag1 = dividend shifting left into the remainder, mag2 = divisor.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_rem_sh;
    logic [WIDTH+1:0]   div_trial;
    logic [2*WIDTH-1:0] acc_mul, acc_div, acc_step, prod;
    logic [WIDTH-1:0]   quo, rem;
    logic               neg;
    logic [WIDTH-1:0]   fix_r1, fix_r2;
    logic               fix_dbz;

    always_comb begin
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mag2_q[0] ? {1'b0, mag1_q} : '0);
        acc_mul    = {mul_sum, acc_q[WIDTH-1:1]};
        div_rem_sh = {acc_q[2*WIDTH-1:WIDTH], mag1_q[WIDTH-1]};
        // Two guard bits: the shifted remainder can exceed WIDTH bits.
        div_trial  = {1'b0, div_rem_sh} - {2'b00, mag2_q};
        if (div_trial[WIDTH+1])
            acc_div = {div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        else
            acc_div = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        acc_step = ctl_q.op ? acc_div : acc_mul;
    end

    // Sign fix-up applied on the last iteration's result.
    always_comb begin
        neg     = ctl_q.sgn && (ctl_q.s1 ^ ctl_q.s2);
        prod    = neg ? -acc_step : acc_step;
        quo     = acc_step[WIDTH-1:0];
        rem     = acc_step[2*WIDTH-1:WIDTH];
        fix_r1  = prod[WIDTH-1:0];
        fix_r2  = prod[2*WIDTH-1:WIDTH];
        fix_dbz = 1'b0;
        if (ctl_q.op) begin
            if (mag2_q == '0) begin
                fix_r1  = '1;
                fix_r2  = raw1_q;
                fix_dbz = 1'b1;
            end else begin
                fix_r1 = neg ? -quo : quo;
                fix_r2 = (ctl_q.sgn && ctl_q.s1) ? -rem : rem;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ctl_d   = ctl_q;
        mag1_d  = mag1_q;
        mag2_d  = mag2_q;
        raw1_d  = raw1_q;
        acc_d   = acc_q;
        res1_d  = res1_q;
        res2_d  = res2_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = COMPUTE;
                    ctl_d.op  = mcycle_op_i;
                    ctl_d.sgn = signed_i;
                    ctl_d.s1  = operand1_i[WIDTH-1];
                    ctl_d.s2  = operand2_i[WIDTH-1];
                    mag1_d    = (signed_i && operand1_i[WIDTH-1]) ? -operand1_i : operand1_i;
                    mag2_d    = (signed_i && operand2_i[WIDTH-1]) ? -operand2_i : operand2_i;
                    raw1_d    = operand1_i;
                    count_d   = '0;
                    acc_d     = '0;
                end
            end
            COMPUTE: begin
                acc_d   = acc_step;
                mag1_d  = ctl_q.op ? (mag1_q << 1) : mag1_q;
                mag2_d  = ctl_q.op ? mag2_q : (mag2_q >> 1);
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    state_d = FINISH;
                    res1_d  = fix_r1;
                    res2_d  = fix_r2;
                    dbz_d   = fix_dbz;
                    done_d  = 1'b1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            count_q <= '0;
            ctl_q   <= '0;
            mag1_q  <= '0;
            mag2_q  <= '0;
            raw1_q  <= '0;
            acc_q   <= '0;
            res1_q  <= '0;
            res2_q  <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ctl_q   <= ctl_d;
            mag1_q  <= mag1_d;
            mag2_q  <= mag2_d;
            raw1_q  <= raw1_d;
            acc_q   <= acc_d;
            res1_q  <= res1_d;
            res2_q  <= res2_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign busy_o        = rst_ni && ((state_q == IDLE && start_i) || state_q == COMPUTE);
    assign done_o        = done_q;
    assign result1_o     = res1_q;
    assign result2_o     = res2_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_mcycle_unit.sv
// Bench for mcycle_unit: a 32-bit and an 8-bit instance checked every cycle
// against an arithmetic reference, plus directed literal expectations.
module tb_mcycle_unit;

    typedef struct packed {
        logic [63:0] r1;
        logic [63:0] r2;
        logic        dz;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        chk_en = 1'b0;
    logic        st[2];
    logic        op[2];
    logic        sg[2];
    logic [63:0] a[2];
    logic [63:0] b[2];
    logic [63:0] r1[2];
    logic [63:0] r2[2];
    logic        busy[2];
    logic        done[2];
    logic        dz[2];
    logic [31:0] r1_32, r2_32;
    logic [7:0]  r1_8, r2_8;

    int total = 0;
    int bad = 0;

    int   m_left[2];
    logic m_done[2];
    res_t m_res[2];
    res_t p_res[2];

    always #5 clk = ~clk;

    mcycle_unit #(.WIDTH(32)) u32 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(st[0]), .mcycle_op_i(op[0]), .signed_i(sg[0]),
        .operand1_i(a[0][31:0]), .operand2_i(b[0][31:0]),
        .result1_o(r1_32), .result2_o(r2_32),
        .busy_o(busy[0]), .done_o(done[0]), .div_by_zero_o(dz[0])
    );

    mcycle_unit #(.WIDTH(8)) u8 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(st[1]), .mcycle_op_i(op[1]), .signed_i(sg[1]),
        .operand1_i(a[1][7:0]), .operand2_i(b[1][7:0]),
        .result1_o(r1_8), .result2_o(r2_8),
        .busy_o(busy[1]), .done_o(done[1]), .div_by_zero_o(dz[1])
    );

    assign r1[0] = {32'd0, r1_32};
    assign r2[0] = {32'd0, r2_32};
    assign r1[1] = {56'd0, r1_8};
    assign r2[1] = {56'd0, r2_8};

    function automatic int wid(input int d);
        return (d == 0) ? 32 : 8;
    endfunction

    // Reference arithmetic on 64-bit integers (widths up to 32 only).
    function automatic res_t model(input int w, input logic o, input logic s,
                                   input logic [63:0] x, input logic [63:0] y);
        res_t        r;
        logic [63:0] m, ux, uy, p;
        longint      sx, sy, sq, sr;
        m  = (64'd1 << w) - 64'd1;
        ux = x & m;
        uy = y & m;
        sx = (s && ux[w-1]) ? longint'(ux | ~m) : longint'(ux);
        sy = (s && uy[w-1]) ? longint'(uy | ~m) : longint'(uy);
        r  = '0;
        if (!o) begin
            if (s) p = 64'(sx * sy);
            else   p = ux * uy;
            r.r1 = p & m;
            r.r2 = (p >> w) & m;
        end else if (uy == 64'd0) begin
            r.r1 = m;
            r.r2 = ux;
            r.dz = 1'b1;
        end else if (s) begin
            sq   = sx / sy;
            sr   = sx % sy;
            r.r1 = m & sq;
            r.r2 = m & sr;
        end else begin
            r.r1 = (ux / uy) & m;
            r.r2 = (ux % uy) & m;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-level expectation: accept in idle, result W cycles later, one done cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_left[d] <= 0;
                m_done[d] <= 1'b0;
                m_res[d]  <= '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (m_left[d] > 0) begin
                    m_left[d] <= m_left[d] - 1;
                    if (m_left[d] == 1) begin
                        m_done[d] <= 1'b1;
                        m_res[d]  <= p_res[d];
                    end
                end else if (m_done[d]) begin
                    m_done[d] <= 1'b0;
                end else if (st[d]) begin
                    p_res[d]  <= model(wid(d), op[d], sg[d], a[d], b[d]);
                    m_left[d] <= wid(d);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("busy[%0d]", d), 64'(busy[d]),
                    64'(rst_n && (m_left[d] > 0 || (!m_done[d] && st[d]))));
                chk($sformatf("done[%0d]", d), 64'(done[d]), 64'(m_done[d]));
                chk($sformatf("result1[%0d]", d), r1[d], m_res[d].r1);
                chk($sformatf("result2[%0d]", d), r2[d], m_res[d].r2);
                chk($sformatf("divbyzero[%0d]", d), 64'(dz[d]), 64'(m_res[d].dz));
            end
        end
    end

    // Returns at the falling edge of the Done cycle.
    task automatic run_op(input int d, input logic o, input logic s,
                          input logic [63:0] x, input logic [63:0] y);
        int lat;
        @(posedge clk); #1;
        st[d] = 1'b1; op[d] = o; sg[d] = s; a[d] = x; b[d] = y;
        @(posedge clk); #1;
        st[d] = 1'b0;
        lat = 1;
        while (lat < 200) begin
            @(negedge clk);
            if (done[d]) break;
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("latency[%0d]", d), 64'(lat), 64'(wid(d) + 1));
    endtask

    initial begin
        int nd, at;
        for (int d = 0; d < 2; d++) begin
            st[d] = 1'b0; op[d] = 1'b0; sg[d] = 1'b0; a[d] = '0; b[d] = '0;
        end
        @(posedge clk); #1;
        chk_en = 1'b1;
        chk("rst_result1", r1[0], 64'd0);
        chk("rst_result2", r2[0], 64'd0);
        chk("rst_done", 64'(done[0]), 64'd0);
        chk("rst_busy", 64'(busy[0]), 64'd0);
        chk("rst_dbz", 64'(dz[0]), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op(0, 1'b0, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFF);
        chk("umul_r1", r1[0], 64'h00000001);
        chk("umul_r2", r2[0], 64'hFFFFFFFE);
        run_op(0, 1'b0, 1'b1, 64'hFFFFFFF9, 64'd6);
        chk("smul_r1", r1[0], 64'hFFFFFFD6);
        chk("smul_r2", r2[0], 64'hFFFFFFFF);
        run_op(0, 1'b0, 1'b1, 64'hFFFFFFFB, 64'hFFFFFFFB);
        chk("smul_nn_r1", r1[0], 64'd25);
        chk("smul_nn_r2", r2[0], 64'd0);
        run_op(0, 1'b1, 1'b0, 64'd100, 64'd7);
        chk("udiv_q", r1[0], 64'd14);
        chk("udiv_r", r2[0], 64'd2);
        run_op(0, 1'b1, 1'b1, 64'hFFFFFF9C, 64'd7);
        chk("sdiv_q", r1[0], 64'hFFFFFFF2);
        chk("sdiv_r", r2[0], 64'hFFFFFFFE);
        run_op(0, 1'b1, 1'b1, 64'd7, 64'hFFFFFFFE);
        chk("sdiv_pos_q", r1[0], 64'hFFFFFFFD);
        chk("sdiv_pos_r", r2[0], 64'd1);
        run_op(0, 1'b1, 1'b1, 64'h80000000, 64'hFFFFFFFF);
        chk("sovf_q", r1[0], 64'h80000000);
        chk("sovf_r", r2[0], 64'd0);
        chk("sovf_dbz", 64'(dz[0]), 64'd0);
        run_op(0, 1'b1, 1'b0, 64'h12345678, 64'd0);
        chk("dz_q", r1[0], 64'hFFFFFFFF);
        chk("dz_r", r2[0], 64'h12345678);
        chk("dz_flag", 64'(dz[0]), 64'd1);
        run_op(0, 1'b1, 1'b1, 64'hFFFFFFF8, 64'd0);
        chk("sdz_q", r1[0], 64'hFFFFFFFF);
        chk("sdz_r", r2[0], 64'hFFFFFFF8);
        chk("sdz_flag", 64'(dz[0]), 64'd1);
        run_op(0, 1'b0, 1'b0, 64'd3, 64'd4);
        chk("mul_after_dz_r1", r1[0], 64'd12);
        chk("mul_after_dz_flag", 64'(dz[0]), 64'd0);

        // Extra Start pulses in COMPUTE (cycle 4) and FINISH (cycle 9) are ignored.
        @(posedge clk); #1;
        st[1] = 1'b1; op[1] = 1'b0; sg[1] = 1'b0; a[1] = 64'd13; b[1] = 64'd11;
        nd = 0;
        at = -1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (done[1]) begin
                nd++;
                at = c;
            end
            @(posedge clk); #1;
            st[1] = (c + 1 == 4) || (c + 1 == 9);
            if (st[1]) begin
                op[1] = 1'b1; a[1] = 64'd200; b[1] = 64'd3;
            end
        end
        st[1] = 1'b0;
        chk("hs_done_count", 64'(nd), 64'd1);
        chk("hs_done_cycle", 64'(at), 64'd9);
        chk("hs_r1", r1[1], 64'd143);

        run_op(1, 1'b0, 1'b1, 64'hFD, 64'd5);
        chk("b8_smul_r1", r1[1], 64'hF1);
        chk("b8_smul_r2", r2[1], 64'hFF);
        run_op(1, 1'b1, 1'b0, 64'd200, 64'd7);
        chk("b2b_q", r1[1], 64'd28);
        chk("b2b_r", r2[1], 64'd4);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("hold_q", r1[1], 64'd28);
        chk("hold_r", r2[1], 64'd4);
        run_op(1, 1'b1, 1'b1, 64'h80, 64'hFF);
        chk("b8_sovf_q", r1[1], 64'h80);
        chk("b8_sovf_r", r2[1], 64'd0);

        // Reset in cycle 10 of a 32-bit divide.
        @(posedge clk); #1;
        st[0] = 1'b1; op[0] = 1'b1; sg[0] = 1'b0; a[0] = 64'd1000; b[0] = 64'd3;
        @(posedge clk); #1;
        st[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_r1", r1[0], 64'd0);
        chk("midrst_r2", r2[0], 64'd0);
        chk("midrst_busy", 64'(busy[0]), 64'd0);
        chk("midrst_done", 64'(done[0]), 64'd0);
        chk("midrst_r1_b8", r1[1], 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op(0, 1'b0, 1'b0, 64'd6, 64'd7);
        chk("post_rst_r1", r1[0], 64'd42);
        chk("post_rst_r2", r2[0], 64'd0);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
